// File: rtl/dg_tribus_rx.sv
// dg_tribus_rx: receive end of the single-wire pulse-pause bus.
// Synchronizes and glitch-filters the line, measures the spacing between
// pause events, decodes each spacing into a bit and delivers whole frames
// through a valid/ready holding register. Errors pulse on err for one cycle.
module dg_tribus_rx #(
    parameter int LOW_MIN  = 4,
    parameter int BIT1_MIN = 96,
    parameter int EOF_CYC  = 256,
    parameter int MAX_BITS = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            a,
    output logic [MAX_BITS-1:0]             out_data,
    output logic [$clog2(MAX_BITS+1)-1:0]   out_len,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            err,
    output logic                            busy
);

    localparam int LW = $clog2(MAX_BITS + 1);
    localparam int CW = $clog2(EOF_CYC + 1);
    localparam int SW = (LOW_MIN > 1) ? $clog2(LOW_MIN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    logic [1:0]          r_sync;
    logic                r_f;
    logic [SW-1:0]       r_stab;
    logic [CW-1:0]       r_cnt;
    logic [MAX_BITS-1:0] r_shift;
    logic [LW-1:0]       r_len;
    logic [MAX_BITS-1:0] r_outData;
    logic [LW-1:0]       r_outLen;
    logic                r_outValid;
    logic                r_err;
    state_t              r_state;

    logic   w_sync;
    logic   w_fFlip;
    logic   w_pause;
    logic   w_cntSat;
    logic   w_bit;
    logic   w_free;
    state_t w_stateNext;
    logic   w_start;
    logic   w_append;
    logic   w_load;
    logic   w_errSet;
    logic   w_toDiscard;

    assign w_sync   = r_sync[1];
    // The filtered level flips once the synchronized line has disagreed with
    // it for LOW_MIN consecutive samples; a 1->0 flip is a pause event.
    assign w_fFlip  = (w_sync != r_f) && (r_stab == SW'(LOW_MIN - 1));
    assign w_pause  = w_fFlip && r_f;
    assign w_cntSat = (r_cnt == CW'(EOF_CYC));
    assign w_bit    = (r_cnt >= CW'(BIT1_MIN));
    assign w_free   = !r_outValid || out_ready;

    assign out_data  = r_outData;
    assign out_len   = r_outLen;
    assign out_valid = r_outValid;
    assign err       = r_err;
    assign busy      = (r_state != ST_IDLE);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], a};
        end
    end

    // Stability filter: count consecutive disagreeing samples, flip on LOW_MIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f    <= 1'b1;
            r_stab <= '0;
        end else if (w_sync == r_f) begin
            r_stab <= '0;
        end else if (w_fFlip) begin
            r_f    <= w_sync;
            r_stab <= '0;
        end else begin
            r_stab <= r_stab + SW'(1);
        end
    end

    // Interval counter: cycles since the last pause, saturating; held at zero
    // while the line is low during discard so recovery needs a full quiet gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_toDiscard) begin
            r_cnt <= '0;
        end else if ((r_state == ST_DISCARD) && (!r_f || w_pause)) begin
            r_cnt <= '0;
        end else if (w_pause) begin
            r_cnt <= CW'(1);
        end else if (!w_cntSat) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and per-cycle actions: start, bit append, frame load, errors.
    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_append    = 1'b0;
        w_load      = 1'b0;
        w_errSet    = 1'b0;
        w_toDiscard = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pause) begin
                    w_start     = 1'b1;
                    w_stateNext = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (w_pause) begin
                    if (r_len == LW'(MAX_BITS)) begin
                        w_errSet    = 1'b1;
                        w_toDiscard = 1'b1;
                        w_stateNext = ST_DISCARD;
                    end else begin
                        w_append = 1'b1;
                    end
                end else if (w_cntSat) begin
                    if (r_f) begin
                        w_stateNext = ST_IDLE;
                        if (r_len != '0) begin
                            if (w_free) begin
                                w_load = 1'b1;
                            end else begin
                                w_errSet = 1'b1;
                            end
                        end
                    end else begin
                        w_errSet    = 1'b1;
                        w_toDiscard = 1'b1;
                        w_stateNext = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_cntSat) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Shift register collects bits LSB-first at index len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_len   <= '0;
        end else if (w_start) begin
            r_shift <= '0;
            r_len   <= '0;
        end else if (w_append) begin
            r_shift <= r_shift | (MAX_BITS'(w_bit) << r_len);
            r_len   <= r_len + LW'(1);
        end
    end

    // Holding register: load a finished frame, clear on handshake otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outLen   <= '0;
            r_outValid <= 1'b0;
        end else if (w_load) begin
            r_outData  <= r_shift;
            r_outLen   <= r_len;
            r_outValid <= 1'b1;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_errSet;
        end
    end

endmodule

// File: tb/tb_dg_tribus_rx.sv
// Testbench for dg_tribus_rx: directed scenarios plus randomized frames,
// compared against a bit-list model of what each frame should deliver.
module tb_dg_tribus_rx;

   localparam int LOW_MIN  = 4;
   localparam int BIT1_MIN = 96;
   localparam int EOF_CYC  = 256;
   localparam int MAX_BITS = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a;
   logic        out_ready;
   logic [31:0] out_data;
   logic [5:0]  out_len;
   logic        out_valid;
   logic        err;
   logic        busy;

   int testsRun    = 0;
   int testsFailed = 0;
   int errSeen     = 0;
   int busySeen    = 0;

   bit txBits[$];

   // Free-running clock
   always #5 clk = ~clk;

   dg_tribus_rx #(
      .LOW_MIN (LOW_MIN),
      .BIT1_MIN(BIT1_MIN),
      .EOF_CYC (EOF_CYC),
      .MAX_BITS(MAX_BITS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .out_data (out_data),
      .out_len  (out_len),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .err      (err),
      .busy     (busy)
   );

   // Count error pulses and busy cycles, sampled away from the active edge
   always @(negedge clk) begin
      if (err === 1'b1) errSeen++;
      if (busy === 1'b1) busySeen++;
   end

   // Safety net so the run always ends
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One bus period: pause low, then high, optionally with a short glitch
   task automatic pulse(input int lowLen, input int period, input bit glitch);
      int h;
      int m;
      h = period - lowLen;
      a = 1'b0;
      tick(lowLen);
      a = 1'b1;
      if (glitch && h >= 30) begin
         m = h / 2;
         tick(m);
         a = 1'b0;
         tick(3);
         a = 1'b1;
         tick(h - m - 3);
      end else begin
         tick(h);
      end
   endtask

   // Send start pause, one period per bit of txBits, final pause, then quiet
   task automatic applyStimulus(input bit randomTiming, input bit glitchEn,
                                input int finalLow, input int quiet);
      for (int i = 0; i < txBits.size(); i++) begin
         int per;
         int lw;
         bit g;
         if (randomTiming) begin
            lw  = int'($urandom_range(12, 4));
            per = txBits[i] ? int'($urandom_range(200, BIT1_MIN)) : int'($urandom_range(BIT1_MIN - 1, 40));
            g   = glitchEn && ($urandom_range(1, 0) == 1);
         end else begin
            lw  = 8;
            per = txBits[i] ? 128 : 64;
            g   = 1'b0;
         end
         pulse(lw, per, g);
      end
      a = 1'b0;
      tick((finalLow > 0) ? finalLow : 8);
      a = 1'b1;
      tick(quiet);
   endtask

   // Reference: first bit sent is worth 1, next 2, and so on
   function automatic longint modelData();
      longint v = 0;
      longint w = 1;
      for (int i = 0; i < txBits.size() && i < MAX_BITS; i++) begin
         if (txBits[i]) v = v + w;
         w = w * 2;
      end
      return v;
   endfunction

   task automatic randomBits(input int n);
      txBits.delete();
      for (int i = 0; i < n; i++) txBits.push_back(bit'($urandom_range(1, 0)));
   endtask

   task automatic waitValid(input string tag);
      int k = 0;
      while (out_valid !== 1'b1 && k < 3000) begin
         tick(1);
         k++;
      end
      checkOutput({tag, "_valid"}, longint'(out_valid), 1);
   endtask

   task automatic ackFrame(input string tag);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      checkOutput({tag, "_cleared"}, longint'(out_valid), 0);
   endtask

   initial begin
      int e0;
      int b0;
      longint expA;
      int lenA;
      logic [7:0] nominal;
      int per[4];

      rst_n = 1'b0;
      a = 1'b1;
      out_ready = 1'b0;

      // Reset with the line toggling
      for (int i = 0; i < 20; i++) begin
         a = 1'($urandom_range(1, 0));
         tick(1);
      end
      checkOutput("rst_valid", longint'(out_valid), 0);
      checkOutput("rst_data", longint'(out_data), 0);
      checkOutput("rst_len", longint'(out_len), 0);
      checkOutput("rst_err", longint'(err), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      a = 1'b1;
      rst_n = 1'b1;
      e0 = errSeen;
      b0 = busySeen;
      tick(1000);
      checkOutput("idle_err", longint'(errSeen - e0), 0);
      checkOutput("idle_busy", longint'(busySeen - b0), 0);

      // Nominal 0xA5 frame with fixed timing
      nominal = 8'hA5;
      txBits.delete();
      for (int i = 0; i < 8; i++) txBits.push_back(bit'((nominal >> i) & 8'h01));
      applyStimulus(1'b0, 1'b0, 0, 300);
      waitValid("nom");
      checkOutput("nom_data", longint'(out_data), modelData());
      checkOutput("nom_len", longint'(out_len), 8);
      tick(50);
      checkOutput("nom_hold_valid", longint'(out_valid), 1);
      checkOutput("nom_hold_data", longint'(out_data), modelData());
      checkOutput("nom_hold_len", longint'(out_len), 8);
      ackFrame("nom");

      // Idle glitch then threshold periods, two of them with mid-bit glitches
      b0 = busySeen;
      a = 1'b0;
      tick(3);
      a = 1'b1;
      tick(30);
      checkOutput("glitch_idle_busy", longint'(busySeen - b0), 0);
      per = '{BIT1_MIN - 1, BIT1_MIN, BIT1_MIN - 1, BIT1_MIN};
      txBits.delete();
      for (int i = 0; i < 4; i++) txBits.push_back(per[i] >= BIT1_MIN);
      for (int i = 0; i < 4; i++) pulse(8, per[i], i < 2);
      a = 1'b0;
      tick(8);
      a = 1'b1;
      tick(300);
      waitValid("thr");
      checkOutput("thr_data", longint'(out_data), modelData());
      checkOutput("thr_len", longint'(out_len), 4);
      ackFrame("thr");

      // Overflow: 33 bits, then a 4-bit frame sent in order 1,0,1,0
      randomBits(MAX_BITS + 1);
      e0 = errSeen;
      applyStimulus(1'b1, 1'b0, 0, 20);
      checkOutput("ovf_err", longint'(errSeen - e0), 1);
      checkOutput("ovf_busy_early", longint'(busy), 1);
      tick(200);
      checkOutput("ovf_busy_mid", longint'(busy), 1);
      tick(100);
      checkOutput("ovf_busy_end", longint'(busy), 0);
      checkOutput("ovf_novalid", longint'(out_valid), 0);
      checkOutput("ovf_err_once", longint'(errSeen - e0), 1);
      txBits = '{1'b1, 1'b0, 1'b1, 1'b0};
      applyStimulus(1'b1, 1'b0, 0, 300);
      waitValid("post_ovf");
      checkOutput("post_ovf_data", longint'(out_data), modelData());
      checkOutput("post_ovf_len", longint'(out_len), 4);
      ackFrame("post_ovf");

      // Overrun: second frame completes while the first is still held
      randomBits(6);
      expA = modelData();
      lenA = txBits.size();
      applyStimulus(1'b1, 1'b1, 0, 300);
      waitValid("ovr_a");
      randomBits(5);
      e0 = errSeen;
      applyStimulus(1'b1, 1'b1, 0, 300);
      checkOutput("ovr_err", longint'(errSeen - e0), 1);
      checkOutput("ovr_valid", longint'(out_valid), 1);
      checkOutput("ovr_data", longint'(out_data), expA);
      checkOutput("ovr_len", longint'(out_len), lenA);
      ackFrame("ovr");

      // Stuck-low mid-frame
      randomBits(3);
      e0 = errSeen;
      applyStimulus(1'b1, 1'b0, 300, 0);
      checkOutput("stuck_err", longint'(errSeen - e0), 1);
      checkOutput("stuck_busy", longint'(busy), 1);
      tick(200);
      checkOutput("stuck_busy_mid", longint'(busy), 1);
      tick(100);
      checkOutput("stuck_busy_end", longint'(busy), 0);
      checkOutput("stuck_novalid", longint'(out_valid), 0);

      // Reset mid-frame while an earlier frame is held
      randomBits(7);
      applyStimulus(1'b1, 1'b0, 0, 300);
      waitValid("rstmid_pre");
      for (int i = 0; i < 6; i++) pulse(8, ($urandom_range(1, 0) == 1) ? 128 : 64, 1'b0);
      checkOutput("rstmid_busy_before", longint'(busy), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_valid", longint'(out_valid), 0);
      checkOutput("rstmid_data", longint'(out_data), 0);
      checkOutput("rstmid_len", longint'(out_len), 0);
      checkOutput("rstmid_busy", longint'(busy), 0);
      tick(3);
      rst_n = 1'b1;
      e0 = errSeen;
      b0 = busySeen;
      tick(400);
      checkOutput("rstmid_after_valid", longint'(out_valid), 0);
      checkOutput("rstmid_after_err", longint'(errSeen - e0), 0);
      checkOutput("rstmid_after_busy", longint'(busySeen - b0), 0);

      // Randomized frames with random timing, glitches and ack delay
      for (int f = 0; f < 8; f++) begin
         int n;
         int d;
         n = int'($urandom_range(MAX_BITS, 1));
         randomBits(n);
         if ($urandom_range(1, 0) == 1) begin
            a = 1'b0;
            tick(3);
            a = 1'b1;
            tick(10);
         end
         e0 = errSeen;
         applyStimulus(1'b1, 1'b1, 0, int'($urandom_range(400, 300)));
         waitValid("rnd");
         checkOutput("rnd_data", longint'(out_data), modelData());
         checkOutput("rnd_len", longint'(out_len), n);
         checkOutput("rnd_err", longint'(errSeen - e0), 0);
         d = int'($urandom_range(20, 0));
         tick(d);
         checkOutput("rnd_hold_data", longint'(out_data), modelData());
         ackFrame("rnd");
         checkOutput("rnd_idle", longint'(busy), 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dg_tribus_rx.md
# dg_tribus_rx

Receive end of the single-wire half-duplex bus driven by the `dg_TRI1`-style tristate gates. The block samples the resolved bus line; undriven means pulled high. It filters glitches and decodes pulse-pause bit timing into frames of up to `MAX_BITS` bits. Each frame is handed to downstream logic through a valid/ready holding register. It sits between the pad receiver and the protocol/crypto logic of the LEGIC prime model.

## Interface
- `LOW_MIN`, default 4: cycles the synchronized line must stay stable before the filtered level changes (both directions).
- `BIT1_MIN`, default 96: bit period at or above this is a 1; below it is a 0.
- `EOF_CYC`, default 256: quiet cycles that end a frame; also the stuck-low limit.
- `MAX_BITS`, default 32: maximum bits per frame.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `a`, input, 1: bus line, asynchronous to `clk`; 1 = idle or undriven, 0 = pause.
- `out_data`, output, `MAX_BITS`: received bits, LSB-first (first bit in bit 0); unused upper bits are 0.
- `out_len`, output, clog2(`MAX_BITS`+1): number of valid bits in `out_data`.
- `out_valid`, output, 1: frame available.
- `out_ready`, input, 1: consumer accepts frame.
- `err`, output, 1: one-cycle pulse on overflow, overrun or stuck-low.
- `busy`, output, 1: high while a frame is in progress or being discarded.

## Operation
- Input path:
  - 2-flop synchronizer on `a`.
  - Stability filter: the filtered level `f` takes the synchronized value after `LOW_MIN` consecutive equal samples.
  - A pause event is a 1→0 transition of `f`.
- Interval counter `cnt`:
  - Width clog2(`EOF_CYC`+1); saturates at `EOF_CYC`.
  - Loads 1 on a pause event; otherwise increments.
  - At a pause event, P = `cnt` before the load, i.e. clk cycles since the previous pause event.
- States:
  - IDLE:
    - `busy`=0.
    - A pause event clears the shift register and bit count, then moves to FRAME. This first pause is the start marker and produces no bit.
  - FRAME:
    - Each pause event appends bit (P ≥ `BIT1_MIN`) at index `len`, then len←len+1.
    - A pause event arriving when len = `MAX_BITS` is an overflow: `err` pulse, go to DISCARD.
    - `cnt`=`EOF_CYC` with `f`=1 ends the frame:
      - If len=0, discard silently and go to IDLE.
      - Otherwise, if the holding register is free, load it and go to IDLE.
      - Otherwise, overrun: `err` pulse, drop the new frame, go to IDLE.
    - `cnt`=`EOF_CYC` with `f`=0 is stuck-low: `err` pulse, go to DISCARD.
  - DISCARD:
    - `cnt` is held at 0 while `f`=0 and counts while `f`=1.
    - Reaching `EOF_CYC` returns to IDLE with no output.
- Holding register:
  - The register is free when `out_valid`=0, or when `out_valid`&`out_ready` in the same cycle as frame end; in that case the new frame loads and `out_valid` stays 1.
  - `out_data` and `out_len` are stable while `out_valid`=1.
  - `out_valid`&`out_ready` with no new frame clears `out_valid` next cycle.
- Error priority: at most one `err` pulse per cycle; overflow, overrun and stuck-low cannot coincide.

## Timing
- Reset values: `out_data`=0, `out_len`=0, `out_valid`=0, `err`=0, `busy`=0, state IDLE.
  - Synchronizer and filter reset to 1 (idle line), so no spurious pause is seen at reset release.
  - Reset mid-frame discards all partial data.
- Edge latency: a raw falling edge on `a` becomes a pause event 2+`LOW_MIN` cycles later. Periods are unaffected because both edges share this latency.
- Minimum detectable pause: `LOW_MIN` cycles low.
- Minimum distinguishable bit period: 2·`LOW_MIN`.
- Frame completion: `out_valid` rises the cycle after `cnt` reaches `EOF_CYC`, i.e. `EOF_CYC`+1 cycles after the last pause event.
- `busy` rises the cycle after the start pause event and falls together with the IDLE transition.
- `err` is registered: it is high for exactly one cycle, the cycle after the detecting condition.

## Test plan
- Reset: hold `rst_n`=0 with `a` toggling → all outputs 0.
  - Release reset with `a`=1 → no `busy` and no `err` for 1000 cycles.
- Nominal frame: start pause, then 8 periods with 0 = 64 cycles and 1 = 128 cycles, encoding 0xA5 LSB-first, each pause 8 cycles low, then 300 cycles high.
  - → `out_valid`=1, `out_data`=0x000000A5, `out_len`=8.
  - Outputs held for 50 cycles with `out_ready`=0; `out_valid` clears one cycle after `out_ready`=1.
- Threshold and glitch:
  - Periods of 95 and 96 decode as 0 and 1.
  - 3-cycle low pulses in idle or mid-bit are ignored: no `busy`, and the bit value is unchanged.
- Overflow: 33 bits sent → one `err` pulse at the 33rd bit pause, no `out_valid`, `busy` held until 256 quiet cycles.
  - An immediately following 4-bit frame of 1010 is received correctly.
- Overrun and stuck-low:
  - Overrun: a second frame completes while the first is unacknowledged → `err` pulse, `out_data` still holds the first frame.
  - Stuck-low: line low for 300 cycles mid-frame → `err`, DISCARD, recovery after 256 high cycles.
- Reset mid-frame: assert `rst_n` after 5 bits → outputs return to 0 asynchronously; no partial frame is delivered after release.
